// File: rtl/calculator_pkg.sv
// Shared calculator definitions: SRAM geometry and the result-reader state encoding.
package calculator_pkg;

  localparam int ADDR_W        = 9;
  localparam int MEM_WORD_SIZE = 64;
  localparam int SRAM_RD_LAT   = 1;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_READ,
    RD_WAIT,
    RD_EMIT_HI,
    RD_EMIT_LO,
    RD_DONE
  } rd_state_e;

endpackage

// File: rtl/result_reader.sv
// Drains a range of 64-bit result words from the SRAM read port and streams each one
// as two 32-bit beats (upper half first) over a valid/ready interface.
module result_reader #(
  parameter int ADDR_W        = calculator_pkg::ADDR_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE,
  parameter int OUT_W         = calculator_pkg::MEM_WORD_SIZE / 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        start_addr_i,
  input  logic [ADDR_W-1:0]        end_addr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     read_o,
  output logic [ADDR_W-1:0]        r_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] r_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [OUT_W-1:0]         out_data_o,
  output logic                     out_last_o
);
  import calculator_pkg::*;

  rd_state_e                state_q, state_d;
  logic [ADDR_W-1:0]        cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]        end_q, end_d;
  logic [MEM_WORD_SIZE-1:0] word_q, word_d;
  logic [1:0]               wait_cnt_q, wait_cnt_d;

  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     read_q, read_d;
  logic [ADDR_W-1:0]        r_addr_q, r_addr_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;

  logic                     hs;
  logic                     at_end;

  assign hs     = out_valid_q & out_ready_i;
  assign at_end = (cur_addr_q == end_q);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    end_d      = end_q;
    word_d     = word_q;
    wait_cnt_d = '0;
    case (state_q)
      RD_IDLE: begin
        if (start_i) begin
          cur_addr_d = start_addr_i;
          end_d      = end_addr_i;
          state_d    = RD_READ;
        end
      end
      RD_READ: state_d = RD_WAIT;
      RD_WAIT: begin
        // Hold in WAIT until the SRAM read latency has elapsed, then capture.
        if (wait_cnt_q == 2'(SRAM_RD_LAT - 1)) begin
          word_d  = r_data_i;
          state_d = RD_EMIT_HI;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      RD_EMIT_HI: begin
        if (hs) state_d = RD_EMIT_LO;
      end
      RD_EMIT_LO: begin
        if (hs) begin
          if (at_end) begin
            state_d = RD_DONE;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            state_d    = RD_READ;
          end
        end
      end
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are flop-driven and hold under stall.
  always_comb begin
    busy_d      = (state_d == RD_READ) || (state_d == RD_WAIT) ||
                  (state_d == RD_EMIT_HI) || (state_d == RD_EMIT_LO);
    done_d      = (state_d == RD_DONE);
    read_d      = (state_d == RD_READ);
    r_addr_d    = (state_d == RD_READ) ? cur_addr_d : '0;
    out_valid_d = (state_d == RD_EMIT_HI) || (state_d == RD_EMIT_LO);
    out_data_d  = '0;
    out_last_d  = 1'b0;
    if (state_d == RD_EMIT_HI) begin
      out_data_d = word_d[MEM_WORD_SIZE-1 -: OUT_W];
    end else if (state_d == RD_EMIT_LO) begin
      out_data_d = word_d[OUT_W-1:0];
      out_last_d = (cur_addr_d == end_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RD_IDLE;
      cur_addr_q  <= '0;
      end_q       <= '0;
      word_q      <= '0;
      wait_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      read_q      <= 1'b0;
      r_addr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      end_q       <= end_d;
      word_q      <= word_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      read_q      <= read_d;
      r_addr_q    <= r_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign read_o      = read_q;
  assign r_addr_o    = r_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader with a one-cycle-latency SRAM model and beat capture.
module tb_result_reader;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [8:0]  start_addr_i;
  logic [8:0]  end_addr_i;
  logic        busy_o;
  logic        done_o;
  logic        read_o;
  logic [8:0]  r_addr_o;
  logic [63:0] r_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        out_last_o;

  logic [63:0] mem [0:511];

  int          vectors = 0;
  int          errors  = 0;
  int          rd_addr[$];
  int          rd_cyc[$];
  logic [32:0] beats[$];

  result_reader dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .start_addr_i(start_addr_i),
    .end_addr_i  (end_addr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .read_o      (read_o),
    .r_addr_o    (r_addr_o),
    .r_data_i    (r_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_o) r_data_i <= mem[r_addr_o];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one drain from start acceptance; optionally applies backpressure, a stray start,
  // or a mid-operation reset at the EMIT_HI of the second word.
  task automatic drain(input int s, input int e, input bit bp, input bit inj_start,
                       input bit inj_rst, output int ncyc, output bit done_seen);
    int          k;
    int          hold;
    bit          held;
    bit          prev_stall;
    logic [31:0] prev_data;
    bit          busy_bad;
    rd_addr.delete();
    rd_cyc.delete();
    beats.delete();
    k = 0; hold = 0; held = 0; prev_stall = 0; prev_data = '0; busy_bad = 0;
    done_seen = 0; ncyc = 0;
    start_addr_i = 9'(s);
    end_addr_i   = 9'(e);
    start_i      = 1'b1;
    out_ready_i  = 1'b1;
    while (k < 200 && !done_seen) begin
      step();
      k++;
      start_i = 1'b0;
      if (inj_start && k == 6) begin
        start_addr_i = 9'd20;
        end_addr_i   = 9'd21;
        start_i      = 1'b1;
      end
      if (read_o) begin
        rd_addr.push_back(int'(r_addr_o));
        rd_cyc.push_back(k);
        chk("read_while_valid", {63'd0, out_valid_o}, 64'd0);
      end
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid_o}, 64'd1);
        chk("stall_data", {32'd0, out_data_o}, {32'd0, prev_data});
      end
      if (done_o) begin
        done_seen = 1;
        ncyc = k;
        if (busy_o) busy_bad = 1;
      end else if (!busy_o) begin
        busy_bad = 1;
      end
      if (inj_rst && out_valid_o && beats.size() == 2) begin
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_read", {63'd0, read_o}, 64'd0);
        chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_data", {32'd0, out_data_o}, 64'd0);
        chk("rst_last", {63'd0, out_last_o}, 64'd0);
        for (int j = 0; j < 6; j++) begin
          step();
          if (done_o || read_o || busy_o) done_seen = 1;
        end
        out_ready_i = 1'b1;
        return;
      end
      if (bp) begin
        if (!held && out_valid_o && beats.size() == 2) begin
          hold = 5;
          held = 1;
        end
        if (hold > 0) begin
          out_ready_i = 1'b0;
          hold--;
        end else begin
          out_ready_i = 1'($urandom_range(0, 1));
        end
      end
      if (out_valid_o && out_ready_i) beats.push_back({out_last_o, out_data_o});
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
    end
    chk("busy_window", {63'd0, busy_bad}, 64'd0);
    out_ready_i = 1'b1;
  endtask

  task automatic check_reads(input int first, input int n, input bit spaced);
    chk("read_count", 64'(rd_addr.size()), 64'(n));
    for (int i = 0; i < n && i < rd_addr.size(); i++) begin
      chk("read_addr", 64'(rd_addr[i]), 64'((first + i) % 512));
      if (spaced) chk("read_cycle", 64'(rd_cyc[i]), 64'(1 + 4 * i));
    end
  endtask

  task automatic check_beats(input int first, input int n);
    logic [63:0] w;
    chk("beat_count", 64'(beats.size()), 64'(2 * n));
    for (int i = 0; i < n && 2 * i + 1 < beats.size(); i++) begin
      w = mem[(first + i) % 512];
      chk("beat_hi", {31'd0, beats[2 * i]}, {31'd0, 1'b0, w[63:32]});
      chk("beat_lo", {31'd0, beats[2 * i + 1]}, {31'd0, (i == n - 1), w[31:0]});
    end
  endtask

  initial begin
    int n;
    bit ds;
    for (int i = 0; i < 512; i++) mem[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
    mem[5] = 64'hAAAA_0001_BBBB_0002;
    for (int i = 0; i < 4; i++) mem[10 + i] = {16'(16'h10 + i), 16'h0, 32'(i)};
    mem[510] = 64'h5100_0000_0000_0510;
    mem[511] = 64'h5110_0000_0000_0511;
    mem[0]   = 64'h0000_F000_0000_0F00;
    mem[1]   = 64'h0001_F001_0001_0F01;

    rst_i = 1'b1; start_i = 1'b0; start_addr_i = '0; end_addr_i = '0; out_ready_i = 1'b0;
    r_data_i = '0;
    step(); step();
    rst_i = 1'b0;
    step();
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_done", {63'd0, done_o}, 64'd0);
    chk("reset_read", {63'd0, read_o}, 64'd0);
    chk("reset_raddr", {55'd0, r_addr_o}, 64'd0);
    chk("reset_valid", {63'd0, out_valid_o}, 64'd0);
    chk("reset_data", {32'd0, out_data_o}, 64'd0);
    chk("reset_last", {63'd0, out_last_o}, 64'd0);

    // Single word, then a start coinciding with done_o must be dropped.
    drain(5, 5, 0, 0, 0, n, ds);
    chk("basic_done_seen", {63'd0, ds}, 64'd1);
    chk("basic_latency", 64'(n), 64'd5);
    check_reads(5, 1, 1);
    check_beats(5, 1);
    start_addr_i = 9'd5; end_addr_i = 9'd5; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_at_done_busy", {63'd0, busy_o}, 64'd0);
    chk("done_single_pulse", {63'd0, done_o}, 64'd0);
    step();
    chk("start_at_done_read", {63'd0, read_o}, 64'd0);
    step();

    drain(10, 13, 0, 0, 0, n, ds);
    chk("multi_done_seen", {63'd0, ds}, 64'd1);
    chk("multi_latency", 64'(n), 64'd17);
    check_reads(10, 4, 1);
    check_beats(10, 4);
    step(); step();

    drain(10, 13, 1, 0, 0, n, ds);
    chk("bp_done_seen", {63'd0, ds}, 64'd1);
    check_reads(10, 4, 0);
    check_beats(10, 4);
    step(); step();

    drain(510, 1, 0, 0, 0, n, ds);
    chk("wrap_done_seen", {63'd0, ds}, 64'd1);
    chk("wrap_latency", 64'(n), 64'd17);
    check_reads(510, 4, 1);
    check_beats(510, 4);
    step();
    chk("wrap_done_once", {63'd0, done_o}, 64'd0);
    step();

    drain(10, 13, 0, 1, 0, n, ds);
    chk("busy_start_done_seen", {63'd0, ds}, 64'd1);
    chk("busy_start_latency", 64'(n), 64'd17);
    check_reads(10, 4, 1);
    check_beats(10, 4);
    step(); step();

    drain(10, 13, 0, 0, 1, n, ds);
    chk("rst_quiet_after", {63'd0, ds}, 64'd0);
    chk("rst_partial_reads", 64'(rd_addr.size()), 64'd2);
    step();

    drain(5, 5, 0, 0, 0, n, ds);
    chk("post_rst_done_seen", {63'd0, ds}, 64'd1);
    chk("post_rst_latency", 64'(n), 64'd5);
    check_reads(5, 1, 1);
    check_beats(5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/result_reader.md
Name: result_reader

Overview:
- Drains the result region of the calculator's 64-bit-wide dual SRAM pair after the controller has written it, acting as the read-side counterpart of the controller's write path.
- Issues reads over the SRAM read port (addr1/csb1 style) and returns each 64-bit word as two 32-bit beats on a valid/ready stream to the test harness or host.
- Sits beside the controller in the top level and shares the read port with it; the top level muxes the port by `busy_o`.

Parameters:
- ADDR_W, 9, SRAM word address width (512 entries).
- MEM_WORD_SIZE, 64, width of one memory word (two 32-bit SRAM halves).
- OUT_W, 32, stream beat width; MEM_WORD_SIZE must equal 2*OUT_W.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to drain [start_addr_i..end_addr_i]; ignored while busy_o=1.
- start_addr_i  in  ADDR_W  first word address, sampled when start_i is accepted.
- end_addr_i  in  ADDR_W  last word address (inclusive), sampled when start_i is accepted.
- busy_o  out  1  high from the cycle after start acceptance until done_o.
- done_o  out  1  one-cycle pulse after the final beat handshakes.
- read_o  out  1  SRAM read enable, active high; the top level inverts it to drive csb1.
- r_addr_o  out  ADDR_W  SRAM read address.
- r_data_i  in  MEM_WORD_SIZE  SRAM read data, valid exactly 1 cycle after read_o.
- out_valid_o  out  1  stream beat valid.
- out_ready_i  in  1  stream beat ready.
- out_data_o  out  OUT_W  stream beat data.
- out_last_o  out  1  high on the final beat of the drain.

Behaviour:
- Reset values: busy_o=0, done_o=0, read_o=0, r_addr_o=0, out_valid_o=0, out_data_o=0, out_last_o=0; FSM in IDLE; internal word and address registers cleared.
- FSM states: IDLE, READ, WAIT, EMIT_HI, EMIT_LO, DONE.
- IDLE:
  - On start_i, latch the start and end addresses into cur_addr and end_q, then go to READ.
  - All outputs are low.
- READ:
  - read_o=1 and r_addr_o=cur_addr for exactly one cycle.
  - Next state is WAIT.
- WAIT:
  - read_o=0.
  - r_data_i is valid this cycle; capture it into word_q.
  - Next state is EMIT_HI.
- EMIT_HI:
  - out_valid_o=1, out_data_o=word_q[63:32], out_last_o=0.
  - Leave the state only on out_valid_o & out_ready_i; next state is EMIT_LO.
- EMIT_LO:
  - out_valid_o=1, out_data_o=word_q[31:0].
  - out_last_o=1 iff cur_addr==end_q.
  - On handshake: if cur_addr==end_q, go to DONE; otherwise cur_addr<=cur_addr+1 (mod 2^ADDR_W) and go to READ.
- DONE:
  - done_o=1 for one cycle, busy_o deasserts in the same cycle, then return to IDLE.
- Registered outputs: out_data_o, out_valid_o and out_last_o are registered and hold stable while out_valid_o & !out_ready_i. The producer never drops valid without a handshake.
- Latency:
  - start_i to first read_o: 1 cycle.
  - read_o to first out_valid_o: 2 cycles.
  - With out_ready_i held high, each word takes 4 cycles (READ, WAIT, HI, LO).
- Word count: (end_q - start_q) mod 2^ADDR_W + 1.
  - end==start drains exactly one word.
  - end<start wraps through 511 to 0; e.g. start=510, end=1 drains 4 words.
- start_i while busy: ignored, with no change to any in-flight address or state.
- start_i in the same cycle as done_o: ignored, because the FSM is in DONE, not IDLE.
- Reset mid-operation: on the next edge, return to IDLE with all outputs at reset values. Any partially emitted word is discarded and no done_o is produced.
- out_ready_i high while out_valid_o low has no effect.

Decomposition:
- calculator_pkg additions:
  - typedef enum logic [2:0] rd_state_e {RD_IDLE, RD_READ, RD_WAIT, RD_EMIT_HI, RD_EMIT_LO, RD_DONE}.
  - localparam SRAM_RD_LAT = 1 (used by WAIT-state sequencing).
- ADDR_W and MEM_WORD_SIZE are reused from calculator_pkg.
- No sub-module is required. The FSM, the address counter and the word register live in a single module of roughly 150-200 lines.

Test Plan:
- Basic drain: preload addr 5 = 64'hAAAA_0001_BBBB_0002, then start=5, end=5 with ready=1. Expect beats 32'hAAAA_0001 then 32'hBBBB_0002 with last on beat 2; exactly one read_o, at addr 5; done_o 5 cycles after start; busy_o high in between.
- Multi-word: preload addrs 10..13 with words whose upper half is {16'h10+i, 16'h0} and lower half is i. Start=10, end=13 with ready=1 → 8 beats in address order, read_o addresses 10,11,12,13 each 4 cycles apart, out_last_o only on beat 8.
- Backpressure: same as the multi-word case, with ready toggled pseudo-randomly (and held low for 5 cycles at the EMIT_HI of word 2). Expect out_data_o/out_valid_o stable while stalled, no beat lost or duplicated, and no new read_o issued until EMIT_LO of the prior word handshakes.
- Wrap-around: start=510, end=1 → reads at 510, 511, 0, 1; 8 beats; done_o once.
- Start while busy: pulse start_i with start=20, end=21 during a drain of 10..13. Expect it ignored (no read at 20); the drain completes normally.
- Reset mid-operation: assert rst_i for 1 cycle during EMIT_HI of the second word. Expect all outputs 0 on the next cycle, no done_o, and FSM in IDLE. A fresh start=5, end=5 afterwards drains correctly.
